// File: rtl/spectrum_peak_hold.sv
// Per-bin spectrum peak hold with timed hold and linear decay.
// A clear sweep zeroes the bin storage after reset; a two-stage read/update pipeline then processes one bin per cycle.
module spectrum_peak_hold #(
   parameter int N     = 6,
   parameter int M     = 64,
   parameter int W     = 8,
   parameter int HOLD  = 30,
   parameter int DECAY = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clk_en,
   input  logic         bin_valid,
   input  logic [N-1:0] bin_idx,
   input  logic [W-1:0] mag,
   output logic         ready,
   output logic         peak_valid,
   output logic [N-1:0] peak_bin,
   output logic [W-1:0] peak_out
);

   localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
   localparam int AW = (M < 2) ? 1 : $clog2(M);

   localparam logic [N:0]    BIN_LIMIT  = (N+1)'(M);
   localparam logic [N-1:0]  LAST_ADDR  = N'(M - 1);
   localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD);
   localparam logic [W-1:0]  DECAY_STEP = W'(DECAY);

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  clr_addr;
   logic [N-1:0]  clr_addr_next;
   logic          clr_we;

   logic [W-1:0]  peak_mem [M];
   logic [HW-1:0] hold_mem [M];

   logic          accept;
   logic          fwd_hit;
   logic [W-1:0]  rd_peak;
   logic [HW-1:0] rd_hold;

   logic          s1_valid;
   logic [N-1:0]  s1_idx;
   logic [W-1:0]  s1_mag;
   logic [W-1:0]  s1_peak;
   logic [HW-1:0] s1_hold;

   logic [W-1:0]  upd_peak;
   logic [HW-1:0] upd_hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end else if (clk_en) begin
         state    <= state_next;
         clr_addr <= clr_addr_next;
      end
   end

   always_comb begin
      state_next    = state;
      clr_addr_next = clr_addr;
      clr_we        = 1'b0;
      case (state)
         CLEAR: begin
            clr_we = 1'b1;
            if (clr_addr == LAST_ADDR) begin
               state_next    = RUN;
               clr_addr_next = '0;
            end else begin
               clr_addr_next = clr_addr + 1'b1;
            end
         end
         RUN: begin
            state_next = RUN;
         end
         default: begin
            state_next = CLEAR;
         end
      endcase
   end

   assign ready = (state == RUN);

   // Out-of-range indices are dropped here, so storage is only ever addressed below M.
   assign accept  = clk_en && (state == RUN) && bin_valid && ({1'b0, bin_idx} < BIN_LIMIT);
   assign fwd_hit = s1_valid && (s1_idx == bin_idx);

   // Stage 2 writes this same edge, so a matching read must take its result instead of the stale entry.
   always_comb begin
      rd_peak = peak_mem[bin_idx[AW-1:0]];
      rd_hold = hold_mem[bin_idx[AW-1:0]];
      if (fwd_hit) begin
         rd_peak = upd_peak;
         rd_hold = upd_hold;
      end
   end

   // A new maximum re-arms the hold timer; otherwise count the hold down, then decay to a floor of zero.
   always_comb begin
      upd_peak = s1_peak;
      upd_hold = s1_hold;
      if (s1_mag >= s1_peak) begin
         upd_peak = s1_mag;
         upd_hold = HOLD_INIT;
      end else if (s1_hold != '0) begin
         upd_hold = s1_hold - 1'b1;
      end else begin
         upd_hold = '0;
         upd_peak = (s1_peak > DECAY_STEP) ? (s1_peak - DECAY_STEP) : '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid   <= 1'b0;
         s1_idx     <= '0;
         s1_mag     <= '0;
         s1_peak    <= '0;
         s1_hold    <= '0;
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_out   <= '0;
      end else if (clk_en) begin
         s1_valid   <= accept;
         if (accept) begin
            s1_idx  <= bin_idx;
            s1_mag  <= mag;
            s1_peak <= rd_peak;
            s1_hold <= rd_hold;
         end
         peak_valid <= s1_valid;
         if (s1_valid) begin
            peak_bin <= s1_idx;
            peak_out <= upd_peak;
         end
      end
   end

   // Storage has no reset; the clear sweep defines it before any sample is accepted.
   always_ff @(posedge clk) begin
      if (clk_en) begin
         if (clr_we) begin
            peak_mem[clr_addr[AW-1:0]] <= '0;
            hold_mem[clr_addr[AW-1:0]] <= '0;
         end else if (s1_valid) begin
            peak_mem[s1_idx[AW-1:0]] <= upd_peak;
            hold_mem[s1_idx[AW-1:0]] <= upd_hold;
         end
      end
   end

endmodule

// File: tb/tb_spectrum_peak_hold.sv
// Directed and randomized bench for spectrum_peak_hold, checked against a sequential per-bin model.
module tb_spectrum_peak_hold;

   localparam int N     = 7;
   localparam int M     = 64;
   localparam int W     = 8;
   localparam int HOLD  = 30;
   localparam int DECAY = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         clk_en = 1'b0;
   logic         bin_valid = 1'b0;
   logic [N-1:0] bin_idx = '0;
   logic [W-1:0] mag = '0;
   logic         ready;
   logic         peak_valid;
   logic [N-1:0] peak_bin;
   logic [W-1:0] peak_out;

   spectrum_peak_hold #(
      .N(N), .M(M), .W(W), .HOLD(HOLD), .DECAY(DECAY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .bin_valid (bin_valid),
      .bin_idx   (bin_idx),
      .mag       (mag),
      .ready     (ready),
      .peak_valid(peak_valid),
      .peak_bin  (peak_bin),
      .peak_out  (peak_out)
   );

   always #5 clk = ~clk;

   int ref_peak [M];
   int ref_hold [M];
   int clr_cnt;
   bit pend_v;
   int pend_bin;
   int pend_pk;
   bit exp_v;
   int exp_bin;
   int exp_pk;
   int last_out;
   int checks;
   int errors;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Samples are applied to the model in arrival order, one at a time.
   function automatic int model_update(input int b, input int m);
      if (m >= ref_peak[b]) begin
         ref_peak[b] = m;
         ref_hold[b] = HOLD;
      end else if (ref_hold[b] > 0) begin
         ref_hold[b] = ref_hold[b] - 1;
      end else begin
         ref_peak[b] = (ref_peak[b] > DECAY) ? ref_peak[b] - DECAY : 0;
      end
      return ref_peak[b];
   endfunction

   task automatic apply_stimulus(input bit en, input bit v, input int idx, input int m);
      bit acc;
      clk_en    = en;
      bin_valid = v;
      bin_idx   = idx[N-1:0];
      mag       = m[W-1:0];
      if (en) begin
         acc     = (clr_cnt >= M) && v && (idx < M);
         exp_v   = pend_v;
         exp_bin = pend_bin;
         exp_pk  = pend_pk;
         pend_v  = acc;
         if (acc) begin
            pend_bin = idx;
            pend_pk  = model_update(idx, m);
         end
         if (clr_cnt < M) clr_cnt++;
      end
      @(posedge clk);
      #1;
      check_output("ready", {31'd0, ready}, {31'd0, clr_cnt >= M});
      check_output("peak_valid", {31'd0, peak_valid}, {31'd0, exp_v});
      if (exp_v) begin
         check_output("peak_bin", 32'(peak_bin), exp_bin);
         check_output("peak_out", 32'(peak_out), exp_pk);
      end
      last_out = int'(peak_out);
   endtask

   task automatic apply_reset(input int cyc);
      reset     = 1'b0;
      clk_en    = 1'b1;
      bin_valid = 1'b0;
      clr_cnt   = 0;
      pend_v    = 1'b0;
      exp_v     = 1'b0;
      for (int b = 0; b < M; b++) begin
         ref_peak[b] = 0;
         ref_hold[b] = 0;
      end
      repeat (cyc) @(posedge clk);
      #1;
      check_output("rst_ready", {31'd0, ready}, 32'd0);
      check_output("rst_peak_valid", {31'd0, peak_valid}, 32'd0);
      check_output("rst_peak_bin", 32'(peak_bin), 32'd0);
      check_output("rst_peak_out", 32'(peak_out), 32'd0);
      reset = 1'b1;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      last_out = 0;
      $display("[TB] reset and clear sweep");
      apply_reset(3);
      for (int i = 0; i < M; i++) apply_stimulus(1'b1, 1'b1, int'($urandom % M), int'($urandom % 256));

      $display("[TB] hold then decay on bin 5");
      apply_stimulus(1'b1, 1'b1, 5, 100);
      repeat (31) apply_stimulus(1'b1, 1'b1, 5, 40);
      apply_stimulus(1'b1, 1'b0, 0, 0);
      check_output("hold_decay_frame32", last_out, 98);

      $display("[TB] decay saturates at zero on bin 9");
      apply_stimulus(1'b1, 1'b1, 9, 3);
      repeat (30) apply_stimulus(1'b1, 1'b1, 9, 0);
      repeat (3) apply_stimulus(1'b1, 1'b1, 9, 0);
      apply_stimulus(1'b1, 1'b0, 0, 0);
      check_output("decay_floor", last_out, 0);

      $display("[TB] back-to-back same bin");
      apply_stimulus(1'b1, 1'b1, 12, 50);
      apply_stimulus(1'b1, 1'b1, 12, 70);
      apply_stimulus(1'b1, 1'b1, 12, 0);
      apply_stimulus(1'b1, 1'b0, 0, 0);
      check_output("same_bin_stored", last_out, 70);

      $display("[TB] enable stall mid-stream");
      apply_stimulus(1'b1, 1'b1, 20, 10);
      apply_stimulus(1'b1, 1'b1, 21, 20);
      repeat (3) apply_stimulus(1'b0, 1'b1, 22, 99);
      apply_stimulus(1'b1, 1'b1, 23, 30);
      repeat (2) apply_stimulus(1'b1, 1'b0, 0, 0);

      $display("[TB] out-of-range bin dropped");
      apply_stimulus(1'b1, 1'b1, M, 200);
      apply_stimulus(1'b1, 1'b1, 0, 0);
      repeat (2) apply_stimulus(1'b1, 1'b0, 0, 0);
      check_output("oob_no_write", last_out, 0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 500; i++) begin
         int idx;
         int m;
         idx = ($urandom % 5 == 0) ? M + int'($urandom % ((1 << N) - M)) : int'($urandom % 6);
         m   = ($urandom % 2 == 0) ? int'($urandom % 256) : int'($urandom % 16);
         apply_stimulus(($urandom % 8) != 0, ($urandom % 4) != 0, idx, m);
      end

      $display("[TB] reset with samples in flight");
      apply_stimulus(1'b1, 1'b1, 2, 77);
      apply_reset(2);
      for (int i = 0; i < M; i++) apply_stimulus(1'b1, 1'b1, int'($urandom % M), 255);
      for (int b = 0; b < M; b++) apply_stimulus(1'b1, 1'b1, b, 0);
      repeat (2) apply_stimulus(1'b1, 1'b0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spectrum_peak_hold.md
SPECTRUM_PEAK_HOLD -- requirements
Module: spectrum_peak_hold

Interface
REQ-001 The block SHALL have parameter N, default 6: bin index width.
REQ-002 The block SHALL have parameter M, default 64: bin count, M <= 2^N.
REQ-003 The block SHALL have parameter W, default 8: magnitude width.
REQ-004 The block SHALL have parameter HOLD, default 30: frames a new peak is held before decay.
REQ-005 The block SHALL have parameter DECAY, default 2: magnitude subtracted per frame once hold expires.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port clk_en, input, 1 bit: global enable; when low, all registers and the clear FSM hold.
REQ-009 The block SHALL have port bin_valid, input, 1 bit: a bin sample is present.
REQ-010 The block SHALL have port bin_idx, input, N bits: bin index, driven by the upstream bin Mod_counter q.
REQ-011 The block SHALL have port mag, input, W bits: magnitude of the current bin.
REQ-012 The block SHALL have port ready, output, 1 bit: high once the clear sweep is complete.
REQ-013 The block SHALL have port peak_valid, output, 1 bit: peak_out is valid.
REQ-014 The block SHALL have port peak_bin, output, N bits: bin index of peak_out.
REQ-015 The block SHALL have port peak_out, output, W bits: held/decayed peak of the bin.

Function
REQ-016 The block SHALL hold per-bin state in M-entry storage: peak (W bits) and hold count (ceil(log2(HOLD+1)) bits).
REQ-017 The FSM SHALL have two states, CLEAR and RUN; CLEAR writes zero to entries 0..M-1, one per clk_en cycle, then enters RUN and sets ready=1.
REQ-018 In CLEAR, bin_valid SHALL be ignored and peak_valid SHALL remain 0.
REQ-019 In RUN, an accepted sample SHALL be one with clk_en=1, bin_valid=1 and bin_idx<M; samples with bin_idx>=M SHALL be dropped with no write and no output.
REQ-020 Stage 1 SHALL read the stored peak P and hold count H at bin_idx and register mag and bin_idx; stage 2 SHALL compute the update, write it back and register the outputs.
REQ-021 The update SHALL be: if mag>=P, then peak=mag and H=HOLD.
REQ-022 Otherwise, if H>0, the update SHALL be peak=P and H=H-1.
REQ-023 Otherwise (H=0), the update SHALL be peak=P-DECAY if P>DECAY, else 0, with H=0; the result SHALL saturate and never wrap.
REQ-024 peak_out SHALL equal the new peak value; peak_bin SHALL equal the accepted bin_idx; peak_valid SHALL pulse for one enabled cycle.
REQ-025 Latency SHALL be exactly 2 enabled clk cycles from the accepted sample to peak_valid.
REQ-026 Back-to-back samples SHALL be accepted every enabled cycle.
REQ-027 When stage 1 reads the index that stage 2 writes in the same cycle, the block SHALL forward the stage-2 write data, so two consecutive samples to the same bin behave as if processed sequentially.
REQ-028 When clk_en=0, the pipeline SHALL freeze with contents and peak_valid preserved, and the sample on the inputs SHALL NOT be accepted.

Reset
REQ-029 While reset=0, the block SHALL enter CLEAR at clear address 0 with ready=0, peak_valid=0, peak_bin=0, peak_out=0 and pipeline valid flags=0.
REQ-030 Reset asserted mid-RUN or mid-CLEAR SHALL abort the current operation, discard in-flight samples, and restart the full clear sweep after release.
REQ-031 Storage contents SHALL be undefined until the sweep completes, and no output SHALL depend on them before ready=1.

Verification
REQ-032 Release reset with clk_en=1 -> ready rises after exactly M cycles; peak_valid=0 throughout the sweep.
REQ-033 Bin 5: mag=100, then mag=40 on each of the next 31 frames (M=64, HOLD=30, DECAY=2) -> peak_out=100 for the first frame and the 30 hold frames, then 98 on frame 32.
REQ-034 Stored peak 3 with H=0, mag=0 -> peak_out=1 next frame, then 0, then stays 0 with no wrap.
REQ-035 Same bin twice in consecutive cycles with mag 50 then 70 -> outputs 50 then 70, and the stored peak is 70.
REQ-036 clk_en low for 3 cycles mid-stream -> outputs frozen, no samples lost or duplicated, and total latency is 2 enabled cycles.
REQ-037 bin_idx=M (with M<2^N) -> no peak_valid pulse and storage unchanged; reset pulse mid-frame -> full re-clear, after which all peaks read 0.
